// File: rtl/spi_master_multi.sv
`default_nettype none
// ============================================================================
// spi_master_multi : SPI master with per-transfer mode, order, divider, select
// Rev 1.0
// ============================================================================
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 3,
  parameter int DIV_W  = 8,
  parameter int SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [SEL_W-1:0]  cs_sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic              sclk,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  localparam int HC_W = $clog2(2 * DATA_W);
  localparam logic [HC_W-1:0]  LAST_HALF = HC_W'(2 * DATA_W - 1);
  localparam logic [SEL_W:0]   CS_LIM    = (SEL_W + 1)'(NUM_CS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [HC_W-1:0]   half_cnt;
  logic              lat_cpol, lat_cpha, lat_lsb;
  logic [DIV_W-1:0]  lat_div;
  logic [DATA_W-1:0] tx_sh, rx_sh, rx_next;
  logic              sel_ok, phase_end, lead, sample_edge, final_edge, sclk_edge, finish;

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  assign sel_ok      = ({1'b0, cs_sel} < CS_LIM);
  assign phase_end   = (div_cnt == lat_div);
  assign lead        = (sclk == lat_cpol);
  assign sample_edge = lead ^ lat_cpha;
  // Edge 2*DATA_W is the trailing edge closing the last half; mosi must not move there.
  assign final_edge  = (state == XFER) && (half_cnt == LAST_HALF - 1'b1);
  assign sclk_edge   = en && phase_end &&
                       ((state == SETUP) || ((state == XFER) && (half_cnt != LAST_HALF)));
  // done lands in the last HOLD cycle; with H=1 that is the cycle right after XFER.
  assign finish      = en && (((state == XFER) && phase_end && (half_cnt == LAST_HALF) && (lat_div == '0)) ||
                              ((state == HOLD) && !done && (div_cnt == lat_div - 1'b1)));
  assign rx_next     = lat_lsb ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      lat_cpol <= 1'b0;
      lat_cpha <= 1'b0;
      lat_lsb  <= 1'b0;
      lat_div  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      sclk     <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sclk <= cpol;
          cs_n <= '1;
          done <= 1'b0;
          busy <= 1'b0;
          if (start && en && sel_ok) begin
            state    <= SETUP;
            busy     <= 1'b1;
            lat_cpol <= cpol;
            lat_cpha <= cpha;
            lat_lsb  <= lsb_first;
            lat_div  <= clk_div;
            div_cnt  <= '0;
            half_cnt <= '0;
            rx_sh    <= '0;
            cs_n     <= ~(NUM_CS'(1) << cs_sel);
            if (!cpha) begin
              mosi  <= first_bit(data_in, lsb_first);
              tx_sh <= shift_word(data_in, lsb_first);
            end else begin
              tx_sh <= data_in;
            end
          end
        end
        SETUP: if (en) begin
          if (phase_end) begin
            state   <= XFER;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        XFER: if (en) begin
          if (phase_end) begin
            div_cnt <= '0;
            if (half_cnt == LAST_HALF) state <= HOLD;
            else                       half_cnt <= half_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (done) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
          end else if (en) begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (sclk_edge) begin
        sclk <= ~sclk;
        if (sample_edge) begin
          rx_sh <= rx_next;
        end else if (!final_edge) begin
          mosi  <= first_bit(tx_sh, lat_lsb);
          tx_sh <= shift_word(tx_sh, lat_lsb);
        end
      end

      if (finish) begin
        done     <= 1'b1;
        cs_n     <= '1;
        data_out <= rx_sh;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_multi.sv
`default_nettype none
// ============================================================================
// tb_spi_master_multi : scoreboard bench with SPI slave model for spi_master_multi
// Rev 1.0
// ============================================================================
module tb_spi_master_multi;

  logic       clk = 1'b0;
  logic       reset, en, start, cpol, cpha, lsb_first;
  logic [7:0] clk_div, data_in, data_out;
  logic [1:0] cs_sel;
  logic       miso, mosi, sclk, busy, done;
  logic [2:0] cs_n;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    int         cyc;
    int         h;
    bit         ivchk;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // slave model state
  logic       loop, s_cpol, s_cpha, s_lsb, s_bit;
  logic [7:0] s_reply, s_rx;
  int         s_k;

  // monitor state
  logic p_busy, p_sclk, p_cs_hi;
  int   rise_cnt, bad_iv, last_tog, last_done;

  assign miso = loop ? mosi : s_bit;

  spi_master_multi #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .clk_div(clk_div), .cs_sel(cs_sel), .data_in(data_in),
    .miso(miso), .mosi(mosi), .cs_n(cs_n), .sclk(sclk), .data_out(data_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer, transfer monitor and SPI slave, all sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [2:0] idx;
    if (!reset) begin
      s_k  = 0;
      s_rx = '0;
    end else begin
      if (busy && !p_busy) begin
        if (last_done >= 0) check_val("cs_gap", int'((cyc - last_done >= 2) && p_cs_hi), 1);
        rise_cnt = 0;
        bad_iv   = 0;
        last_tog = cyc;
      end else if (busy && (sclk != p_sclk)) begin
        if (sclk) rise_cnt++;
        if (sb.size() > 0 && (cyc - last_tog) != sb[0].h) bad_iv++;
        last_tog = cyc;
      end
      if (done) begin
        last_done = cyc;
        if (sb.size() == 0) begin
          check_val("done_unexp", 1, 0);
        end else begin
          e = sb.pop_front();
          check_val("data_out", data_out, e.rx);
          check_val("slave_rx", s_rx, e.tx);
          check_val("done_cyc", cyc, e.cyc);
          check_val("sclk_rises", rise_cnt, 8);
          if (e.ivchk) check_val("half_period", bad_iv, 0);
        end
      end
      if (cs_n == 3'b111) begin
        s_k  = 0;
        s_rx = '0;
      end else if ((sclk != p_sclk) && ((sclk != s_cpol) ^ s_cpha)) begin
        s_rx = s_lsb ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
        s_k++;
      end
    end
    idx     = s_lsb ? 3'(s_k) : 3'(7 - s_k);
    s_bit   = (s_k < 8) ? s_reply[idx] : 1'b0;
    p_busy  = busy;
    p_sclk  = sclk;
    p_cs_hi = (cs_n == 3'b111);
  end

  task automatic do_xfer(input logic pol, input logic pha, input logic lsb, input logic [7:0] div,
                         input logic [1:0] sel, input logic [7:0] d, input logic [7:0] rep,
                         input logic lp, input int extra, input bit iv);
    exp_t e;
    @(negedge clk);
    cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div; cs_sel = sel; data_in = d;
    loop = lp; s_cpol = pol; s_cpha = pha; s_lsb = lsb; s_reply = rep;
    start = 1'b1;
    e.rx = lp ? d : rep;
    e.tx = d;
    e.h  = int'(div) + 1;
    e.cyc = cyc + e.h * 18 + extra;
    e.ivchk = iv;
    sb.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    data_in = ~d;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) begin
      check_val("timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_busy(input logic v, input int lim);
    int n = 0;
    while (busy !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (busy !== v) check_val("wait_busy", int'(busy), int'(v));
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_mosi"}, mosi, 0);
    check_val({tag, "_cs_n"}, cs_n, 3'b111);
    check_val({tag, "_sclk"}, sclk, 0);
    check_val({tag, "_dout"}, data_out, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] dv [3];
    logic [5:0] snap;
    exp_t e;
    int exp_c;
    bit any_busy, any_cs, any_done;

    reset = 1'b0; en = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    clk_div = '0; cs_sel = '0; data_in = '0; loop = 1'b1;
    s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0; s_reply = '0; s_k = 0; s_rx = '0;
    p_busy = 1'b0; p_sclk = 1'b0; p_cs_hi = 1'b1;
    rise_cnt = 0; bad_iv = 0; last_tog = 0; last_done = -1;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // mode 0, loopback, fastest divider
    do_xfer(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'hA5, 8'h00, 1'b1, 0, 1'b1);
    check_val("m0_cs_n", cs_n, 3'b110);
    wait_done(100);

    // mode 3, LSB first, divider 3, slave answers 0xC3
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_hi", sclk, 1);
    do_xfer(1'b1, 1'b1, 1'b1, 8'd3, 2'd1, 8'h3C, 8'hC3, 1'b0, 0, 1'b1);
    check_val("m3_cs_n", cs_n, 3'b101);
    wait_done(200);

    // out-of-range select is ignored
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    repeat (2) @(negedge clk);
    cs_sel = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    any_busy = 0; any_cs = 0; any_done = 0;
    for (int i = 0; i < 20; i++) begin
      any_busy |= busy;
      any_cs   |= (cs_n != 3'b111);
      any_done |= done;
      @(negedge clk);
    end
    check_val("badsel_busy", any_busy, 0);
    check_val("badsel_cs", any_cs, 0);
    check_val("badsel_done", any_done, 0);

    // enable dropped for 5 cycles mid-transfer
    do_xfer(1'b0, 1'b0, 1'b0, 8'd1, 2'd2, 8'h96, 8'h69, 1'b0, 5, 1'b0);
    repeat (8) @(negedge clk);
    en = 1'b0;
    snap = {1'b0, 1'b0, sclk, mosi, cs_n};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("freeze", {1'b0, 1'b0, sclk, mosi, cs_n}, snap);
    end
    en = 1'b1;
    wait_done(200);

    // asynchronous reset in the middle of bit 4
    do_xfer(1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 8'hE7, 8'h00, 1'b1, 0, 1'b0);
    repeat (18) @(negedge clk);
    check_val("pre_rst_busy", busy, 1);
    #2 reset = 1'b0;
    #1 check_reset_vals("arst");
    e = sb.pop_back();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_xfer(1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 8'h5A, 8'h00, 1'b1, 0, 1'b1);
    wait_done(200);

    // start held high: back-to-back transfers, data_in changed while busy
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33;
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0; cs_sel = 2'd2;
    loop = 1'b1; s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0;
    data_in = dv[0];
    start = 1'b1;
    exp_c = cyc + 18;
    e.rx = dv[0]; e.tx = dv[0]; e.cyc = exp_c; e.h = 1; e.ivchk = 1'b1;
    sb.push_back(e);
    for (int k = 0; k < 3; k++) begin
      wait_busy(1'b1, 50);
      if (k == 0) check_val("b2b_cs_n", cs_n, 3'b011);
      if (k < 2) begin
        data_in = dv[k+1];
        exp_c = exp_c + 19;
        e.rx = dv[k+1]; e.tx = dv[k+1]; e.cyc = exp_c;
        sb.push_back(e);
      end else begin
        start = 1'b0;
        data_in = 8'hFF;
      end
      wait_busy(1'b0, 50);
    end
    wait_done(100);

    check_val("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
